// File: rtl/ysyx_exu_mc.sv
// Multi-cycle execute unit: base RV integer ops in one registered cycle, M-ext mul/div iterative.
// Optional macro YSYX_EXU_MDU_EN builds the BUSY state and mul/div datapath; otherwise M ops are NOPs.
module ysyx_exu_mc #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [6:0]      op,
    input  logic [4:0]      rd,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            gpr_wen,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] dnpc,
    input  logic            kill
);
    localparam logic [1:0] S_IDLE = 2'd0;
`ifdef YSYX_EXU_MDU_EN
    localparam logic [1:0] S_BUSY = 2'd1;
`endif
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam int         SHW      = $clog2(XLEN);

    logic [1:0]      state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic            gpr_wen_q, gpr_wen_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] dnpc_q, dnpc_d;

    logic [XLEN-1:0] pc_plus4, jalr_t, dnpc_base, alu_a, alu_b, alu_res;
    logic [SHW-1:0]  shamt;
    logic            is_alu, is_sb, is_m, alt;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign gpr_wen   = gpr_wen_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign dnpc      = dnpc_q;

    assign pc_plus4 = pc + XLEN'(4);
    assign jalr_t   = rs1 + imm;
    assign is_alu   = (op == OP_R) || (op == OP_I);
    assign is_sb    = (op == OP_S) || (op == OP_B);
    assign is_m     = (op == OP_R) && (func7 == 7'b0000001);
    assign shamt    = alu_b[SHW-1:0];

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (op)
            OP_R:              begin alu_a = rs1; alu_b = rs2; end
            OP_I:              begin alu_a = rs1; alu_b = imm; end
            OP_LUI:            alu_a = imm;
            OP_AUIPC:          begin alu_a = pc; alu_b = imm; end
            OP_JAL, OP_JALR:   alu_a = pc_plus4;
            default:           ;
        endcase
    end

    // SUB exists only for R-type; SRA/SRAI both key off func7[5]
    always_comb begin
        alt     = func7[5];
        alu_res = alu_a + alu_b;
        if (is_alu) begin
            case (func3)
                3'b000:  alu_res = (alt && op == OP_R) ? alu_a - alu_b : alu_a + alu_b;
                3'b001:  alu_res = alu_a << shamt;
                3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
                3'b011:  alu_res = {{(XLEN-1){1'b0}}, alu_a < alu_b};
                3'b100:  alu_res = alu_a ^ alu_b;
                3'b101:  alu_res = alt ? XLEN'($signed(alu_a) >>> shamt) : alu_a >> shamt;
                3'b110:  alu_res = alu_a | alu_b;
                default: alu_res = alu_a & alu_b;
            endcase
        end
    end

    always_comb begin
        case (op)
            OP_JAL:  dnpc_base = pc + imm;
            OP_JALR: dnpc_base = {jalr_t[XLEN-1:1], 1'b0};
            default: dnpc_base = pc_plus4;
        endcase
    end

`ifdef YSYX_EXU_MDU_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d, rs1_q, rs1_d, pc4_q, pc4_d;
    logic [4:0]        rd_q, rd_d;
    logic [2:0]        f3_q, f3_d;
    logic              negq_q, negq_d, negr_q, negr_d;

    logic              a_sgn, b_sgn, sa, sb, last;
    logic [XLEN-1:0]   ma, mb, quo, rem, mdu_res;
    logic [XLEN:0]     mul_sum, div_rsh, div_diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, step, prod;

    // acc holds {hi, lo} product for mul and {remainder, dividend/quotient} for div
    always_comb begin
        a_sgn    = func3[2] ? ~func3[0] : (func3[1:0] == 2'b01 || func3[1:0] == 2'b10);
        b_sgn    = func3[2] ? ~func3[0] : (func3[1:0] == 2'b01);
        sa       = a_sgn & rs1[XLEN-1];
        sb       = b_sgn & rs2[XLEN-1];
        ma       = sa ? -rs1 : rs1;
        mb       = sb ? -rs2 : rs2;
        last     = (cnt_q == CNT_W'(XLEN-1));
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
        div_rsh  = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_rsh - {1'b0, opb_q};
        div_nxt  = div_diff[XLEN] ? {div_rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        step     = f3_q[2] ? div_nxt : mul_nxt;
        prod     = negq_q ? -step : step;
        quo      = negq_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem      = negr_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        if (f3_q[2]) begin
            if (opb_q == '0) mdu_res = f3_q[1] ? rs1_q : '1;
            else             mdu_res = f3_q[1] ? rem : quo;
        end else begin
            mdu_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        gpr_wen_d   = gpr_wen_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        dnpc_d      = dnpc_q;
`ifdef YSYX_EXU_MDU_EN
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opb_d  = opb_q;
        rs1_d  = rs1_q;
        pc4_d  = pc4_q;
        rd_d   = rd_q;
        f3_d   = f3_q;
        negq_d = negq_q;
        negr_d = negr_q;
`endif
        if (kill) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
`ifdef YSYX_EXU_MDU_EN
                    if (is_m) begin
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        acc_d   = {{XLEN{1'b0}}, ma};
                        opb_d   = mb;
                        rs1_d   = rs1;
                        pc4_d   = pc_plus4;
                        rd_d    = rd;
                        f3_d    = func3;
                        negq_d  = sa ^ sb;
                        negr_d  = sa;
                    end else
`endif
                    begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        gpr_wen_d   = !(is_sb || is_m);
                        waddr_d     = (is_sb || is_m) ? 5'd0 : rd;
                        wdata_d     = is_m ? '0 : alu_res;
                        dnpc_d      = dnpc_base;
                    end
                end
`ifdef YSYX_EXU_MDU_EN
                S_BUSY: begin
                    acc_d = step;
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        gpr_wen_d   = 1'b1;
                        waddr_d     = rd_q;
                        wdata_d     = mdu_res;
                        dnpc_d      = pc4_q;
                    end
                end
`endif
                S_DONE: if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            gpr_wen_q   <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            dnpc_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            gpr_wen_q   <= gpr_wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            dnpc_q      <= dnpc_d;
        end
    end

`ifdef YSYX_EXU_MDU_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            opb_q  <= '0;
            rs1_q  <= '0;
            pc4_q  <= '0;
            rd_q   <= '0;
            f3_q   <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opb_q  <= opb_d;
            rs1_q  <= rs1_d;
            pc4_q  <= pc4_d;
            rd_q   <= rd_d;
            f3_q   <= f3_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
        end
    end
`endif
endmodule

// File: tb/tb_ysyx_exu_mc.sv
// Self-checking bench for ysyx_exu_mc (XLEN=32) against a behavioural reference model.
module tb_ysyx_exu_mc;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] pc = '0, imm = '0, rs1 = '0, rs2 = '0;
    logic [6:0]  op = '0, func7 = '0;
    logic [4:0]  rd = '0;
    logic [2:0]  func3 = '0;
    logic        out_valid, out_ready = 1'b1;
    logic        gpr_wen;
    logic [4:0]  waddr;
    logic [31:0] wdata, dnpc;
    logic        kill = 1'b0;

    int checks = 0;
    int errors = 0;

    ysyx_exu_mc #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .imm(imm), .op(op), .rd(rd), .func3(func3), .func7(func7),
        .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
        .gpr_wen(gpr_wen), .waddr(waddr), .wdata(wdata), .dnpc(dnpc), .kill(kill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                                        input logic sub, input logic sra);
        logic signed [31:0] xs;
        xs = x;
        case (f3)
            3'd0: return sub ? x - y : x + y;
            3'd1: return x << y[4:0];
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return sra ? 32'(xs >>> y[4:0]) : x >> y[4:0];
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic void model(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [4:0] r, input logic [31:0] p, input logic [31:0] im,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic ew, output logic [4:0] ea, output logic [31:0] ed,
                                  output logic [31:0] en, output int el);
        logic [63:0] prod;
        ew = 1'b1; ea = r; ed = '0; en = p + 32'd4; el = 1;
        case (o)
            OP_R: if (f7 == 7'b0000001) begin
`ifdef YSYX_EXU_MDU_EN
                el = 33;
                case (f3)
                    3'd0: begin prod = {32'd0, a} * {32'd0, b}; ed = prod[31:0]; end
                    3'd1: begin prod = {{32{a[31]}}, a} * {{32{b[31]}}, b}; ed = prod[63:32]; end
                    3'd2: begin prod = {{32{a[31]}}, a} * {32'd0, b}; ed = prod[63:32]; end
                    3'd3: begin prod = {32'd0, a} * {32'd0, b}; ed = prod[63:32]; end
                    3'd4, 3'd6: begin
                        if (b == 0) ed = (f3 == 3'd4) ? 32'hFFFF_FFFF : a;
                        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ed = (f3 == 3'd4) ? a : 32'd0;
                        else ed = (f3 == 3'd4) ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
                    end
                    default: begin
                        if (b == 0) ed = (f3 == 3'd5) ? 32'hFFFF_FFFF : a;
                        else ed = (f3 == 3'd5) ? a / b : a % b;
                    end
                endcase
`else
                ew = 1'b0; ea = 5'd0;
`endif
            end else ed = alu(f3, a, b, f7[5], f7[5]);
            OP_I:     ed = alu(f3, a, im, 1'b0, f7[5]);
            OP_LUI:   ed = im;
            OP_AUIPC: ed = p + im;
            OP_JAL:   begin ed = p + 32'd4; en = p + im; end
            OP_JALR:  begin ed = p + 32'd4; en = (a + im) & 32'hFFFF_FFFE; end
            default:  begin ew = 1'b0; ea = 5'd0; end
        endcase
    endfunction

    task automatic run_op(input logic [6:0] t_op, input logic [2:0] t_f3, input logic [6:0] t_f7,
                          input logic [4:0] t_rd, input logic [31:0] t_pc, input logic [31:0] t_imm,
                          input logic [31:0] t_a, input logic [31:0] t_b, input int hold);
        logic ew; logic [4:0] ea; logic [31:0] ed, en; int el; int lat;
        model(t_op, t_f3, t_f7, t_rd, t_pc, t_imm, t_a, t_b, ew, ea, ed, en, el);
        lat = 0;
        while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("in_ready_idle", in_ready, 1);
        op = t_op; func3 = t_f3; func7 = t_f7; rd = t_rd; pc = t_pc; imm = t_imm;
        rs1 = t_a; rs2 = t_b; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("out_valid", out_valid, 1);
        chk("latency", lat, el);
        chk("gpr_wen", gpr_wen, ew);
        if (ew || t_op != OP_R) chk("waddr", waddr, ea);
        chk("wdata", wdata, ed);
        chk("dnpc", dnpc, en);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_wdata", wdata, ed);
            chk("hold_dnpc", dnpc, en);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("valid_drop", out_valid, 0);
    endtask

    initial begin
        logic [6:0] ops [8];
        logic [6:0] f7;
        logic [31:0] b;
        ops = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_S, OP_B};

        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_wen", gpr_wen, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_dnpc", dnpc, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(OP_I, 3'd0, 7'd0, 5'd7, 32'h8000_0000, 32'hFFFF_FFFD, 32'd5, 32'd0, 0);
        chk("addi_literal", wdata, 32'd2);
        run_op(OP_JALR, 3'd0, 7'd0, 5'd1, 32'h8000_0010, 32'd4, 32'h8000_0101, 32'd0, 3);
        chk("jalr_literal", dnpc, 32'h8000_0104);
        run_op(OP_R, 3'd0, 7'd1, 5'd3, 32'h100, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(OP_R, 3'd3, 7'd1, 5'd4, 32'h104, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(OP_R, 3'd4, 7'd1, 5'd5, 32'h108, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(OP_R, 3'd6, 7'd1, 5'd6, 32'h10C, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_op(OP_R, 3'd5, 7'd1, 5'd8, 32'h110, 32'd0, 32'h1234_5678, 32'd0, 0);
        run_op(OP_R, 3'd7, 7'd1, 5'd9, 32'h114, 32'd0, 32'd9, 32'd0, 0);
        run_op(OP_R, 3'd4, 7'd1, 5'd10, 32'h118, 32'd0, 32'hFFFF_FF9C, 32'd7, 0);
        run_op(OP_R, 3'd6, 7'd1, 5'd11, 32'h11C, 32'd0, 32'hFFFF_FF9C, 32'd7, 0);
        run_op(OP_R, 3'd2, 7'd1, 5'd12, 32'h120, 32'd0, 32'hFFFF_FFFE, 32'h8000_0003, 0);

        // kill of a held result
        op = OP_R; func3 = 3'd0; func7 = 7'd0; rd = 5'd2; rs1 = 32'd1; rs2 = 32'd2;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        chk("pre_kill_valid", out_valid, 1);
        kill = 1'b1;
        @(posedge clk); #1; kill = 1'b0;
        chk("kill_done_valid", out_valid, 0);
        chk("kill_done_ready", in_ready, 1);

        // kill beats a simultaneous accept
        in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0; kill = 1'b0;
        chk("kill_prio_valid", out_valid, 0);
        chk("kill_prio_ready", in_ready, 1);
        out_ready = 1'b1;

`ifdef YSYX_EXU_MDU_EN
        op = OP_R; func3 = 3'd4; func7 = 7'd1; rd = 5'd3; rs1 = 32'd100; rs2 = 32'd7;
        in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1; kill = 1'b0;
        chk("kill_busy_valid", out_valid, 0);
        chk("kill_busy_ready", in_ready, 1);
        repeat (40) @(posedge clk);
        #1 chk("kill_busy_quiet", out_valid, 0);
`endif
        run_op(OP_R, 3'd0, 7'd0, 5'd13, 32'h200, 32'd0, 32'd40, 32'd2, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'h01;
            endcase
            b = ($urandom_range(4) == 0) ? 32'd0 : $urandom;
            run_op(ops[$urandom_range(7)], 3'($urandom_range(7)), f7, 5'($urandom_range(31)),
                   $urandom & 32'hFFFF_FFFC, $urandom, $urandom, b, $urandom_range(2));
        end

        // reset pulse while an M op is in flight (or held as a NOP result)
        op = OP_R; func3 = 3'd0; func7 = 7'd1; rd = 5'd14; pc = 32'h300; rs1 = 32'd3; rs2 = 32'd5;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_wen", gpr_wen, 0);
        chk("mid_rst_waddr", waddr, 0);
        chk("mid_rst_wdata", wdata, 0);
        chk("mid_rst_dnpc", dnpc, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        run_op(OP_LUI, 3'd0, 7'd0, 5'd15, 32'h400, 32'hABCD_E000, 32'd0, 32'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
